// File: rtl/elevator_request_manager.sv
`default_nettype none
// ============================================================================
//  Module   : elevator_request_manager
//  Purpose  : Synchronises and debounces floor call buttons, latches pending
//             calls, picks the next target with a SCAN policy and drives a
//             stable one-hot request to the elevator controller.
//  Revision : 1.0 - initial release
// ============================================================================
module elevator_request_manager #(
    parameter int NUM_FLOORS      = 3,
    parameter int FLOOR_W         = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  direction,
    input  logic                  door,
    output logic [NUM_FLOORS-1:0] req,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  busy
);

    localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACTIVE  = 2'd1,
        S_SERVING = 2'd2
    } state_t;

    logic [NUM_FLOORS-1:0] r_sync1;
    logic [NUM_FLOORS-1:0] r_sync2;
    logic [NUM_FLOORS-1:0] r_pending;
    logic [NUM_FLOORS-1:0] r_req;
    logic [FLOOR_W-1:0]    r_target;
    logic                  r_busy;
    state_t                r_state;

    logic [NUM_FLOORS-1:0] w_press;
    logic [NUM_FLOORS-1:0] w_clr;
    logic                  w_up_found;
    logic                  w_dn_found;
    logic                  w_cur_pend;
    logic [FLOOR_W-1:0]    w_up_idx;
    logic [FLOOR_W-1:0]    w_dn_idx;
    logic                  w_sel_valid;
    logic [FLOOR_W-1:0]    w_sel_idx;
    logic                  w_sel_clr;
    state_t                w_state_nxt;
    logic [NUM_FLOORS-1:0] w_req_nxt;
    logic [FLOOR_W-1:0]    w_tgt_nxt;

    // Two-flop synchroniser for the raw asynchronous buttons
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_floor
            logic [c_CNT_W-1:0] r_cnt;

            // Saturating run-length counter of synchronised-high samples
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (!r_sync2[i]) begin
                    r_cnt <= '0;
                end else if (r_cnt != c_CNT_W'(DEBOUNCE_CYCLES)) begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end

            // One press per hold: fires only on the sample that completes the run
            assign w_press[i] = r_sync2[i] && (r_cnt == c_CNT_W'(DEBOUNCE_CYCLES - 1));
            // Car standing at this floor with the door open serves the call
            assign w_clr[i]   = door && (int'(current_floor) == i);
        end
    endgenerate

    // Pending calls: clear dominates a simultaneous press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending | w_press) & ~w_clr;
        end
    end

    // SCAN candidates: nearest above, nearest below, and the current floor
    always_comb begin
        w_up_found = 1'b0;
        w_up_idx   = '0;
        w_dn_found = 1'b0;
        w_dn_idx   = '0;
        w_cur_pend = 1'b0;
        // Descending walk so the last hit is the lowest floor above
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (r_pending[i] && (i > int'(current_floor))) begin
                w_up_found = 1'b1;
                w_up_idx   = FLOOR_W'(i);
            end
        end
        // Ascending walk so the last hit is the highest floor below
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (r_pending[i] && (i < int'(current_floor))) begin
                w_dn_found = 1'b1;
                w_dn_idx   = FLOOR_W'(i);
            end
            if (r_pending[i] && (i == int'(current_floor))) begin
                w_cur_pend = 1'b1;
            end
        end
    end

    // Direction-dependent priority among the candidates
    always_comb begin
        w_sel_valid = 1'b1;
        w_sel_idx   = current_floor;
        if (direction) begin
            if (w_up_found)      w_sel_idx = w_up_idx;
            else if (w_dn_found) w_sel_idx = w_dn_idx;
            else                 w_sel_valid = w_cur_pend;
        end else begin
            if (w_dn_found)      w_sel_idx = w_dn_idx;
            else if (w_up_found) w_sel_idx = w_up_idx;
            else                 w_sel_valid = w_cur_pend;
        end
        // Selected floor is being served right now; do not issue it
        w_sel_clr = door && (current_floor == w_sel_idx);
    end

    // FSM next-state and registered-output values
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_tgt_nxt   = r_target;
        case (r_state)
            S_IDLE: begin
                w_req_nxt = '0;
                if (w_sel_valid && !w_sel_clr) begin
                    w_tgt_nxt   = w_sel_idx;
                    w_req_nxt   = NUM_FLOORS'(1) << w_sel_idx;
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (door && (current_floor == r_target)) begin
                    w_req_nxt   = '0;
                    w_state_nxt = S_SERVING;
                end
            end
            S_SERVING: begin
                w_req_nxt = '0;
                if (!door) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_req_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_req    <= '0;
            r_target <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_req    <= w_req_nxt;
            r_target <= w_tgt_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
        end
    end

    assign req          = r_req;
    assign pending      = r_pending;
    assign target_floor = r_target;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_elevator_request_manager.sv
`default_nettype none
// ============================================================================
//  Module   : tb_elevator_request_manager
//  Purpose  : Self-checking bench for elevator_request_manager: directed
//             scenarios plus randomized traffic against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_elevator_request_manager;

    localparam int N  = 3;
    localparam int FW = 2;
    localparam int D  = 4;

    localparam int M_IDLE    = 0;
    localparam int M_ACTIVE  = 1;
    localparam int M_SERVING = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  btn;
    logic [FW-1:0] current_floor;
    logic          direction;
    logic          door;
    logic [N-1:0]  req;
    logic [N-1:0]  pending;
    logic [FW-1:0] target_floor;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [N-1:0] m_sync1, m_sync2, m_pend, m_req;
    int           m_run [N];
    int           m_mode;
    int           m_tgt;

    elevator_request_manager #(
        .NUM_FLOORS(N), .FLOOR_W(FW), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk), .reset(reset), .btn(btn), .current_floor(current_floor),
        .direction(direction), .door(door), .req(req), .pending(pending),
        .target_floor(target_floor), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_sync1 = '0; m_sync2 = '0; m_pend = '0; m_req = '0;
        m_mode = M_IDLE; m_tgt = 0;
        for (int f = 0; f < N; f++) m_run[f] = 0;
    endtask

    // SCAN choice computed directly from the list of pending floors
    function automatic int pick(input logic [N-1:0] pend, input int cf, input bit up);
        int lo_above = -1;
        int hi_below = -1;
        int here     = -1;
        for (int f = 0; f < N; f++) begin
            if (pend[f]) begin
                if (f > cf && (lo_above < 0 || f < lo_above)) lo_above = f;
                if (f < cf && f > hi_below) hi_below = f;
                if (f == cf) here = f;
            end
        end
        if (up) begin
            if (lo_above >= 0) return lo_above;
            if (hi_below >= 0) return hi_below;
        end else begin
            if (hi_below >= 0) return hi_below;
            if (lo_above >= 0) return lo_above;
        end
        return here;
    endfunction

    // Advance the model across one clock edge, then compare all outputs
    task automatic cycle();
        logic [N-1:0] press, clr;
        int cf, sel;
        cf = int'(current_floor);
        for (int f = 0; f < N; f++) begin
            press[f] = m_sync2[f] && (m_run[f] == D - 1);
            clr[f]   = door && (cf == f);
        end
        case (m_mode)
            M_IDLE: begin
                m_req = '0;
                sel = pick(m_pend, cf, direction);
                if (sel >= 0 && !(door && sel == cf)) begin
                    m_tgt  = sel;
                    m_req  = N'(1) << sel;
                    m_mode = M_ACTIVE;
                end
            end
            M_ACTIVE: if (door && cf == m_tgt) begin
                m_req  = '0;
                m_mode = M_SERVING;
            end
            default: begin
                m_req = '0;
                if (!door) m_mode = M_IDLE;
            end
        endcase
        m_pend = (m_pend | press) & ~clr;
        for (int f = 0; f < N; f++) m_run[f] = m_sync2[f] ? m_run[f] + 1 : 0;
        m_sync2 = m_sync1;
        m_sync1 = btn;
        @(posedge clk);
        #1;
        check_eq("req", int'(req), int'(m_req));
        check_eq("pending", int'(pending), int'(m_pend));
        check_eq("target_floor", int'(target_floor), m_tgt);
        check_eq("busy", int'(busy), int'(m_mode != M_IDLE));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; btn = '0; current_floor = '0; direction = 1'b1; door = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_req", int'(req), 0);
        check_eq("reset_pending", int'(pending), 0);
        check_eq("reset_target", int'(target_floor), 0);
        check_eq("reset_busy", int'(busy), 0);
        reset = 1'b0;

        // Held press at floor 2, car at 0 going up
        btn = 3'b100; current_floor = 2'd0; direction = 1'b1; door = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (k == 5) check_eq("latency_pend_e5", int'(pending), 0);
            if (k == 6) check_eq("latency_pend_e6", int'(pending), 4);
            if (k == 7) begin
                check_eq("first_req", int'(req), 4);
                check_eq("first_target", int'(target_floor), 2);
                check_eq("first_busy", int'(busy), 1);
            end
        end

        // Service floor 2, then close the door
        btn = '0; current_floor = 2'd2; door = 1'b1;
        cycle();
        check_eq("serve_pending", int'(pending), 0);
        check_eq("serve_req", int'(req), 0);
        check_eq("serve_busy", int'(busy), 1);
        door = 1'b0;
        cycle();
        check_eq("serve_idle", int'(busy), 0);

        // Short glitch must not register
        do_reset();
        current_floor = 2'd0; door = 1'b0; btn = 3'b010;
        repeat (3) cycle();
        btn = '0;
        repeat (8) cycle();
        check_eq("glitch_pending", int'(pending), 0);
        check_eq("glitch_req", int'(req), 0);

        // SCAN going up and going down from floor 1 with calls at 0 and 2
        for (int d = 1; d >= 0; d--) begin
            do_reset();
            current_floor = 2'd1; door = 1'b0; direction = d[0]; btn = 3'b101;
            repeat (7) cycle();
            check_eq("scan_target", int'(target_floor), d ? 2 : 0);
            check_eq("scan_req", int'(req), d ? 4 : 1);
        end

        // Press at the occupied floor with the door open, then with it closed
        do_reset();
        current_floor = 2'd1; direction = 1'b1; door = 1'b1; btn = 3'b010;
        repeat (10) cycle();
        check_eq("setclr_pending", int'(pending), 0);
        check_eq("setclr_req", int'(req), 0);
        btn = '0;
        repeat (4) cycle();
        door = 1'b0; btn = 3'b010;
        repeat (7) cycle();
        check_eq("set_pending", int'(pending), 2);
        check_eq("set_req", int'(req), 2);

        // Asynchronous reset while ACTIVE with two calls pending
        do_reset();
        current_floor = 2'd2; direction = 1'b0; door = 1'b0; btn = 3'b011;
        repeat (8) cycle();
        check_eq("pre_areset_pending", int'(pending), 3);
        check_eq("pre_areset_busy", int'(busy), 1);
        #1;
        reset = 1'b1;
        #1;
        check_eq("areset_req", int'(req), 0);
        check_eq("areset_pending", int'(pending), 0);
        check_eq("areset_busy", int'(busy), 0);
        model_clear();
        btn = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) cycle();
        check_eq("post_areset_pending", int'(pending), 0);

        // Randomized traffic with sticky inputs so presses survive debounce
        for (int k = 0; k < 3000; k++) begin
            for (int f = 0; f < N; f++)
                if ($urandom_range(7) == 0) btn[f] = ~btn[f];
            if ($urandom_range(3) == 0) door = ~door;
            if ($urandom_range(5) == 0) current_floor = FW'($urandom_range(3));
            if ($urandom_range(5) == 0) direction = ~direction;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
